// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit CPU: program RAM and data RAM with
// combinational reads. It also owns boot: it streams the program image in
// byte by byte, zero-fills data RAM, and then releases the CPU from reset.
module cpu_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] programAddress,
    output logic [DATA_W-1:0] programData,
    input  logic [ADDR_W-1:0] dataAddress,
    input  logic [DATA_W-1:0] writeData,
    input  logic              WE,
    output logic [DATA_W-1:0] readData,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   load_count,
    output logic              load_error
);

    typedef enum logic [2:0] {LOAD_LO, LOAD_HI, CLEAR, RUN, ERROR} state_t;

    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, stateNext;
    logic [ADDR_W:0]   loadCount, loadCountNext;
    logic [ADDR_W-1:0] clr, clrNext;
    logic [7:0]        lowByte, lowByteNext;
    logic              progWe, dmemWe;
    logic [ADDR_W-1:0] dmemAddr;
    logic [DATA_W-1:0] dmemWdata;
    logic [15:0]       loadWord;

    logic [DATA_W-1:0] prog [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    // The write pointer and the word count advance together, so the pointer
    // is simply the low bits of the count; the extra count bit flags DEPTH.
    logic [ADDR_W-1:0] ptr;
    assign ptr        = loadCount[ADDR_W-1:0];
    assign loadWord   = {ld_data, lowByte};
    assign load_count = loadCount;

    // State and boot counters; reset restarts the load at word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD_LO;
            loadCount <= '0;
            clr       <= '0;
            lowByte   <= '0;
        end else begin
            state     <= stateNext;
            loadCount <= loadCountNext;
            clr       <= clrNext;
            lowByte   <= lowByteNext;
        end
    end

    // Next state, RAM write strobes and status outputs.
    always_comb begin
        stateNext     = state;
        loadCountNext = loadCount;
        clrNext       = clr;
        lowByteNext   = lowByte;
        progWe        = 1'b0;
        dmemWe        = 1'b0;
        dmemAddr      = dataAddress;
        dmemWdata     = writeData;
        ld_ready      = 1'b0;
        cpu_reset     = 1'b1;
        load_error    = 1'b0;
        case (state)
            LOAD_LO: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    lowByteNext = ld_data;
                    // A final byte in the low slot means an odd-length image.
                    stateNext   = ld_last ? ERROR : LOAD_HI;
                end
            end
            LOAD_HI: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    progWe        = 1'b1;
                    loadCountNext = loadCount + 1'b1;
                    if (ld_last)                     stateNext = CLEAR;
                    else if (loadCount == LAST_WORD) stateNext = ERROR;
                    else                             stateNext = LOAD_LO;
                end
            end
            CLEAR: begin
                dmemWe    = 1'b1;
                dmemAddr  = clr;
                dmemWdata = '0;
                clrNext   = clr + 1'b1;
                if (clr == LAST_ADDR) stateNext = RUN;
            end
            RUN: begin
                cpu_reset = 1'b0;
                dmemWe    = WE;
            end
            ERROR: begin
                load_error = 1'b1;
            end
            default: stateNext = LOAD_LO;
        endcase
    end

    // Program RAM: written only by the loader; contents survive reset.
    always_ff @(posedge clk) begin
        if (progWe) prog[ptr] <= DATA_W'(loadWord);
    end

    // Data RAM: zero-filled during CLEAR, CPU stores during RUN.
    always_ff @(posedge clk) begin
        if (dmemWe) dmem[dmemAddr] <= dmemWdata;
    end

    // Single-cycle datapath reads; forced to zero while the CPU is held.
    assign programData = cpu_reset ? '0 : prog[programAddress];
    assign readData    = cpu_reset ? '0 : dmem[dataAddress];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized bench for cpu_mem_responder against a word-level model of the
// boot image and data RAM.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  programAddress = '0;
    logic [15:0] programData;
    logic [9:0]  dataAddress = '0;
    logic [15:0] writeData = '0;
    logic        WE = 1'b0;
    logic [15:0] readData;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_reset;
    logic [10:0] load_count;
    logic        load_error;

    int errCnt = 0;
    int chkCnt = 0;

    logic [15:0] progModel [1024];
    logic [15:0] dmemModel [1024];
    logic [15:0] img [$];

    cpu_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .programAddress(programAddress), .programData(programData),
        .dataAddress(dataAddress), .writeData(writeData), .WE(WE),
        .readData(readData),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_reset(cpu_reset),
        .load_count(load_count), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Random CPU-side traffic; must have no effect outside RUN.
    task automatic noise();
        WE          = 1'($urandom_range(0, 1));
        dataAddress = 10'($urandom);
        writeData   = 16'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOuts(input string tag);
        chk({tag, ".cpuReset"}, cpu_reset, 1);
        chk({tag, ".ldReady"}, ld_ready, 1);
        chk({tag, ".loadCount"}, load_count, 0);
        chk({tag, ".loadError"}, load_error, 0);
        chk({tag, ".progData"}, programData, 0);
        chk({tag, ".readData"}, readData, 0);
    endtask

    // Asserts reset between clock edges and checks its immediate effect.
    task automatic doReset(input string tag);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        WE       = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkResetOuts(tag);
        #3;
        reset_n = 1'b1;
        step();
    endtask

    task automatic sendByte(input logic [7:0] b, input bit last, input int gapMax);
        int g;
        g = $urandom_range(0, gapMax);
        repeat (g) begin
            ld_valid = 1'b0;
            noise();
            step();
        end
        noise();
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        chk("ldReady", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        WE       = 1'b0;
    endtask

    // Sends the whole image (low byte first) and records it in the model.
    task automatic loadBytes(input int gapMax);
        for (int i = 0; i < img.size(); i++) begin
            sendByte(img[i][7:0], 1'b0, gapMax);
            sendByte(img[i][15:8], i == img.size() - 1, gapMax);
            progModel[i] = img[i];
        end
        chk("loadCount", load_count, img.size());
    endtask

    // Counts cycles from the last accepted byte until the CPU is released.
    task automatic waitRun();
        int cycles;
        cycles = 0;
        while (cycles < 1100) begin
            noise();
            step();
            cycles++;
            if (!cpu_reset) break;
        end
        WE = 1'b0;
        chk("clearCycles", cycles, 1024);
        for (int i = 0; i < 1024; i++) dmemModel[i] = '0;
    endtask

    task automatic verifyRun(input int n);
        int bad;
        WE = 1'b0;
        for (int i = 0; i < n; i++) begin
            programAddress = 10'(i);
            #1;
            chk("progWord", programData, progModel[i]);
        end
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            dataAddress = 10'(a);
            #1;
            if (readData !== 16'h0000) bad++;
        end
        chk("dmemZero", bad, 0);
        chk("ldReadyRun", ld_ready, 0);
    endtask

    initial begin
        int bad;
        #1;
        doReset("rst0");

        // Directed image with gaps and store noise during load/clear.
        img = {16'h1234, 16'h5678, 16'h9ABC};
        loadBytes(3);
        waitRun();
        verifyRun(3);

        // Single store: old value in the store cycle, new value afterwards.
        dataAddress = 10'd5; writeData = 16'hBEEF; WE = 1'b1;
        #1;
        chk("storeOld", readData, 16'h0000);
        step();
        WE = 1'b0;
        #1;
        chk("storeNew", readData, 16'hBEEF);
        dmemModel[5] = 16'hBEEF;
        dataAddress = 10'd4; #1; chk("store4", readData, 16'h0000);
        dataAddress = 10'd6; #1; chk("store6", readData, 16'h0000);

        // Random stores over a narrow window to force address reuse.
        for (int i = 0; i < 60; i++) begin
            logic [9:0]  a;
            logic [15:0] d;
            logic        w;
            a = 10'($urandom_range(0, 15));
            d = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            dataAddress = a; writeData = d; WE = w;
            #1;
            chk("rdBefore", readData, dmemModel[a]);
            @(posedge clk);
            if (w) dmemModel[a] = d;
            #1;
            WE = 1'b0;
            #1;
            chk("rdAfter", readData, dmemModel[a]);
        end

        // Reset from RUN, then mid-LOAD_HI, then mid-CLEAR.
        doReset("rstRun");
        sendByte(8'h77, 1'b0, 0);
        doReset("rstHi");
        img = {16'h4321, 16'h8765};
        loadBytes(0);
        repeat (200) step();
        doReset("rstClr");
        img = {16'h55AA};
        loadBytes(0);
        waitRun();
        verifyRun(1);

        // Odd-length image: error is sticky and the CPU stays held.
        doReset("rstOdd");
        sendByte(8'h11, 1'b0, 0);
        sendByte(8'h22, 1'b0, 0);
        sendByte(8'h33, 1'b1, 0);
        chk("oddErr", load_error, 1);
        chk("oddReady", ld_ready, 0);
        chk("oddCpuRst", cpu_reset, 1);
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom_range(0, 1));
            noise();
            step();
            if (cpu_reset !== 1'b1 || load_error !== 1'b1 || ld_ready !== 1'b0) bad++;
        end
        ld_valid = 1'b0; ld_last = 1'b0; WE = 1'b0;
        chk("oddHold", bad, 0);

        // Overflow: DEPTH words without a last byte.
        doReset("rstOvf");
        for (int i = 0; i < 2048; i++) begin
            if (i == 2047) chk("ovfNotYet", load_error, 0);
            sendByte(8'($urandom), 1'b0, 0);
        end
        chk("ovfErr", load_error, 1);
        chk("ovfReady", ld_ready, 0);
        chk("ovfCount", load_count, 1024);
        ld_valid = 1'b1; ld_data = 8'hEE;
        #1;
        chk("ovfByte2049", ld_ready, 0);
        step();
        ld_valid = 1'b0;
        chk("ovfCountHold", load_count, 1024);

        // Random images with random gaps.
        for (int t = 0; t < 3; t++) begin
            int n;
            doReset("rstRnd");
            n = $urandom_range(1, 24);
            img = {};
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            loadBytes(4);
            waitRun();
            verifyRun(n);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
